// File: rtl/vga_timing_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_controller_if
// Purpose  : Bundles the signals between the VGA timing controller, the
//            horizontal sync generator and the mode-control client.
// Ports    : master modport = controller side
//              in : LineEnd, mode_req, mode_sel
//              out: mode_ack, active_mode, PixelClock, hreset,
//                   SynchPulse, BackPorch, ActiveVideo, FrontPorch,
//                   vsync, vactive, yposition, FrameEnd
//            slave modport  = hsync generator / mode client side
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_controller_if #(
    parameter int XRES = 10,
    parameter int YRES = 10
) ();
    logic            LineEnd;
    logic            mode_req;
    logic            mode_sel;
    logic            mode_ack;
    logic            active_mode;
    logic            PixelClock;
    logic            hreset;
    logic [XRES-1:0] SynchPulse;
    logic [XRES-1:0] BackPorch;
    logic [XRES-1:0] ActiveVideo;
    logic [XRES-1:0] FrontPorch;
    logic            vsync;
    logic            vactive;
    logic [YRES-1:0] yposition;
    logic            FrameEnd;

    modport master (
        input  LineEnd, mode_req, mode_sel,
        output mode_ack, active_mode, PixelClock, hreset,
               SynchPulse, BackPorch, ActiveVideo, FrontPorch,
               vsync, vactive, yposition, FrameEnd
    );

    modport slave (
        output LineEnd, mode_req, mode_sel,
        input  mode_ack, active_mode, PixelClock, hreset,
               SynchPulse, BackPorch, ActiveVideo, FrontPorch,
               vsync, vactive, yposition, FrameEnd
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_controller
// Purpose  : Drives the horizontal sync generator (pixel clock, config,
//            reset), runs the vertical timing FSM from LineEnd pulses and
//            switches between two timing modes only at frame boundaries.
// Ports    : clock - system clock
//            reset - asynchronous active-low reset
//            bus   - vga_timing_controller_if.master (LineEnd, mode req/ack,
//                    PixelClock, hreset, horizontal config, vsync, vactive,
//                    yposition, FrameEnd)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_controller #(
    parameter int CLKDIV = 4,
    parameter int XRES   = 10,
    parameter int YRES   = 10,
    parameter int M0_HSP = 96,
    parameter int M0_HBP = 48,
    parameter int M0_HAV = 640,
    parameter int M0_HFP = 16,
    parameter int M0_VSP = 2,
    parameter int M0_VBP = 33,
    parameter int M0_VAV = 480,
    parameter int M0_VFP = 10,
    parameter int M1_HSP = 3,
    parameter int M1_HBP = 4,
    parameter int M1_HAV = 6,
    parameter int M1_HFP = 2,
    parameter int M1_VSP = 2,
    parameter int M1_VBP = 3,
    parameter int M1_VAV = 4,
    parameter int M1_VFP = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    vga_timing_controller_if.master bus
);
    localparam int              HALF     = CLKDIV / 2;
    localparam int              DIVW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(HALF - 1);

    typedef enum logic [1:0] {
        V_SYNC   = 2'd0,
        V_BACK   = 2'd1,
        V_ACTIVE = 2'd2,
        V_FRONT  = 2'd3
    } vstate_t;

    vstate_t         state, state_next;
    logic [YRES-1:0] ycount, ycount_next;
    logic [YRES-1:0] seg_len, seg_last;
    logic            frame_wrap;
    logic            switch_now;
    logic            new_mode;

    logic [DIVW-1:0] div_cnt;
    logic            pclk;
    logic            hreset_q;
    logic            hreset_hold;
    logic            mode;
    logic            pending;
    logic            pend_mode;
    logic [XRES-1:0] hsp, hbp, hav, hfp;
    logic            vsync_q, vactive_q, frame_end_q, ack_q;
    logic [YRES-1:0] ypos_q;

    // Vertical FSM: next state and segment bookkeeping
    always_comb begin
        seg_len     = '0;
        state_next  = state;
        ycount_next = ycount;
        frame_wrap  = 1'b0;
        case (state)
            V_SYNC:   seg_len = mode ? YRES'(M1_VSP) : YRES'(M0_VSP);
            V_BACK:   seg_len = mode ? YRES'(M1_VBP) : YRES'(M0_VBP);
            V_ACTIVE: seg_len = mode ? YRES'(M1_VAV) : YRES'(M0_VAV);
            V_FRONT:  seg_len = mode ? YRES'(M1_VFP) : YRES'(M0_VFP);
            default:  seg_len = '0;
        endcase
        // A zero-length segment still occupies one line so no state is skipped
        seg_last = (seg_len == '0) ? '0 : seg_len - YRES'(1);
        if (bus.LineEnd) begin
            if (ycount == seg_last) begin
                ycount_next = '0;
                case (state)
                    V_SYNC:   state_next = V_BACK;
                    V_BACK:   state_next = V_ACTIVE;
                    V_ACTIVE: state_next = V_FRONT;
                    V_FRONT: begin
                        state_next = V_SYNC;
                        frame_wrap = 1'b1;
                    end
                    default:  state_next = V_SYNC;
                endcase
            end else begin
                ycount_next = ycount + YRES'(1);
            end
        end
    end

    // A request arriving on the wrap edge itself wins over any older one
    assign switch_now = frame_wrap & (pending | bus.mode_req);
    assign new_mode   = bus.mode_req ? bus.mode_sel : pend_mode;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= V_SYNC;
            ycount <= '0;
        end else begin
            state  <= state_next;
            ycount <= ycount_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            pclk        <= 1'b0;
            hreset_q    <= 1'b1;
            hreset_hold <= 1'b1;
            mode        <= 1'b0;
            pending     <= 1'b0;
            pend_mode   <= 1'b0;
            hsp         <= XRES'(M0_HSP);
            hbp         <= XRES'(M0_HBP);
            hav         <= XRES'(M0_HAV);
            hfp         <= XRES'(M0_HFP);
            vsync_q     <= 1'b0;
            vactive_q   <= 1'b0;
            ypos_q      <= '0;
            frame_end_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            // Free-running divider, independent of mode changes
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                pclk    <= ~pclk;
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
            end

            // hreset covers the current clock plus one more after a trigger
            if (switch_now) begin
                hreset_q    <= 1'b1;
                hreset_hold <= 1'b1;
            end else if (hreset_hold) begin
                hreset_q    <= 1'b1;
                hreset_hold <= 1'b0;
            end else begin
                hreset_q    <= 1'b0;
            end

            if (switch_now) begin
                mode    <= new_mode;
                pending <= 1'b0;
                hsp     <= new_mode ? XRES'(M1_HSP) : XRES'(M0_HSP);
                hbp     <= new_mode ? XRES'(M1_HBP) : XRES'(M0_HBP);
                hav     <= new_mode ? XRES'(M1_HAV) : XRES'(M0_HAV);
                hfp     <= new_mode ? XRES'(M1_HFP) : XRES'(M0_HFP);
            end else if (bus.mode_req) begin
                pending   <= 1'b1;
                pend_mode <= bus.mode_sel;
            end

            vsync_q     <= (state_next != V_SYNC);
            vactive_q   <= (state_next == V_ACTIVE);
            ypos_q      <= (state_next == V_ACTIVE) ? ycount_next : '0;
            frame_end_q <= frame_wrap;
            ack_q       <= switch_now;
        end
    end

    assign bus.PixelClock  = pclk;
    assign bus.hreset      = hreset_q;
    assign bus.active_mode = mode;
    assign bus.mode_ack    = ack_q;
    assign bus.SynchPulse  = hsp;
    assign bus.BackPorch   = hbp;
    assign bus.ActiveVideo = hav;
    assign bus.FrontPorch  = hfp;
    assign bus.vsync       = vsync_q;
    assign bus.vactive     = vactive_q;
    assign bus.yposition   = ypos_q;
    assign bus.FrameEnd    = frame_end_q;
endmodule
`default_nettype wire

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the horizontal sync generator: produces its PixelClock, drives its four timing-config inputs, and controls its reset.
- Counts its LineEnd pulses to run the vertical timing FSM, producing vsync, yposition, vactive and FrameEnd.
- Holds two timing modes (full VGA and a small test mode) and switches between them only at a frame boundary, using a req/ack handshake.

Parameters:
- CLKDIV, 4, clock cycles per PixelClock period; even and ≥2.
- XRES, 10, width of the horizontal config buses.
- YRES, 10, width of yposition and the vertical counters.
- M0_HSP/M0_HBP/M0_HAV/M0_HFP, 96/48/640/16, mode 0 horizontal timing in pixels.
- M0_VSP/M0_VBP/M0_VAV/M0_VFP, 2/33/480/10, mode 0 vertical timing in lines.
- M1_HSP/M1_HBP/M1_HAV/M1_HFP, 3/4/6/2, mode 1 horizontal timing in pixels.
- M1_VSP/M1_VBP/M1_VAV/M1_VFP, 2/3/4/1, mode 1 vertical timing in lines.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- LineEnd  in  1  one-clock pulse from the hsync generator.
- mode_req  in  1  mode-change request, level-sampled.
- mode_sel  in  1  requested mode (0 or 1).
- mode_ack  out  1  one-clock pulse when the new mode is applied.
- active_mode  out  1  mode currently in force.
- PixelClock  out  1  divided pixel clock to the hsync generator.
- hreset  out  1  active-high reset to the hsync generator.
- SynchPulse, BackPorch, ActiveVideo, FrontPorch  out  XRES each  horizontal config of the active mode.
- vsync  out  1  active-low vertical sync.
- vactive  out  1  high during vertical active lines.
- yposition  out  YRES  active line index.
- FrameEnd  out  1  one-clock end-of-frame pulse.

Behaviour:
- Reset (reset low, asynchronous):
  - PixelClock=0, hreset=1.
  - Horizontal config = mode 0 values, active_mode=0.
  - FSM=V_SYNC, ycount=0, so vsync=0.
  - vactive=0, yposition=0, FrameEnd=0, mode_ack=0, pending=0.
- hreset stays 1 for 2 clocks after reset deasserts, then 0.
- PixelClock:
  - Divider counter 0..CLKDIV/2-1; PixelClock toggles when the counter wraps.
  - First rising edge comes CLKDIV/2 clocks after reset release.
  - Period is exactly CLKDIV clocks, free-running, and unaffected by mode changes.
- Vertical FSM:
  - States V_SYNC → V_BACK → V_ACTIVE → V_FRONT → V_SYNC.
  - FSM advances only on LineEnd.
  - On LineEnd: if ycount == seglen-1, go to next state and set ycount=0; else ycount+1.
  - A segment length of 0 is treated as 1; no state is ever skipped.
- Vertical outputs (registered, updated the clock after the causing LineEnd):
  - vsync=0 exactly in V_SYNC.
  - vactive=1 exactly in V_ACTIVE.
  - yposition=ycount in V_ACTIVE, 0 otherwise.
- FrameEnd: 1 for the single clock following the LineEnd that leaves V_FRONT.
- Mode request:
  - Any clock with mode_req=1 latches mode_sel into pend_mode and sets pending=1.
  - A later request before the switch overwrites pend_mode (last request wins).
  - Requesting the mode already active is still acknowledged at the next boundary.
- Mode switch, in the clock FrameEnd is asserted:
  - If pending (including a request in that same clock), active_mode=pend_mode.
  - Horizontal config and vertical segment lengths switch to the new mode; pending clears.
  - mode_ack=1 for that clock; hreset=1 for that clock and the next.
  - FSM is already in V_SYNC with ycount=0.
- Horizontal config outputs change only at reset or at a mode switch; they are glitch-free registers.
- LineEnd arriving while hreset=1 is still counted; LineEnd is not expected to arrive faster than once per 2 clocks.
- Reset asserted mid-frame or mid-request: everything returns to reset values immediately, and any pending request is lost.

Test Plan:
- Reset with CLKDIV=4 → SynchPulse=96, BackPorch=48, ActiveVideo=640, FrontPorch=16, vsync=0, hreset=1; after release hreset drops 2 clocks later; PixelClock first rises 2 clocks after release, period 4.
- Mode 1 active, 10 LineEnd pulses spaced 8 clocks → vsync=0 during lines 0-1, vactive=1 during lines 5-8 with yposition 0,1,2,3, FrameEnd one clock after the 10th pulse, vsync=0 again.
- Mode 0 running, mode_req=1/mode_sel=1 for 1 clock at line 3 → config stays 96/48/640/16 until FrameEnd after line 524; then 3/4/6/2, mode_ack 1 clock, hreset 2 clocks, active_mode=1.
- Requests for mode 1 then mode 0 in the same frame, starting in mode 1 → at FrameEnd active_mode=0, single mode_ack pulse; request coincident with FrameEnd applies in that clock.
- Async reset low mid-V_ACTIVE (yposition=2) with a request pending → outputs reset in the same time step without a clock edge; no mode_ack at the next FrameEnd.
- Override M1_VBP=0 → frame is 2+1+4+1=8 lines, V_BACK lasts exactly 1 line.
